config_packet_builder: RTL

//  Transmit-side peer of the config-packet authenticator. Frames a config payload

---
 rtl/config_packet_builder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/config_packet_builder.sv
`default_nettype none
// ============================================================================
//  Module      : config_packet_builder
//  Description : Frames a config payload into an authenticated AXI-Stream
//                packet: MAGIC word, {16'h0, seq_id} word, then the payload.
//                The sequence id advances per packet for anti-replay and never
//                takes the value zero. A single output register stage gives
//                full 1 word/clk throughput under continuous m_axis_tready.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_packet_builder #(
    parameter int          AXI_DATA_WIDTH    = 32,
    parameter int          MAX_PAYLOAD_WORDS = 256,
    parameter logic [31:0] MAGIC             = 32'hDEADBEEF,
    parameter logic [15:0] SEQ_INIT          = 16'h0001,
    localparam int         LEN_W             = $clog2(MAX_PAYLOAD_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,

    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,

    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,

    output logic [31:0]      pkt_sent_cnt,
    output logic [31:0]      len_err_cnt,
    output logic [15:0]      next_seq_id,
    output logic             busy
);

    // The datapath is hard-wired to 32-bit words; any other width is rejected.
    generate
        if (AXI_DATA_WIDTH != 32) begin : g_bad_width
            $error("config_packet_builder: AXI_DATA_WIDTH must be 32");
        end
    endgenerate

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_hdr_magic = 3'd1;
    localparam logic [2:0] c_st_hdr_seq   = 3'd2;
    localparam logic [2:0] c_st_payload   = 3'd3;
    localparam logic [2:0] c_st_drain     = 3'd4;

    localparam logic [3:0] c_keep_all     = 4'hF;

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_word_cnt;
    logic [15:0]      r_next_seq;
    logic [31:0]      r_tdata;
    logic [3:0]       r_tkeep;
    logic             r_tlast;
    logic             r_tvalid;
    logic [31:0]      r_pkt_cnt;
    logic [31:0]      r_err_cnt;

    logic             w_load_ok;
    logic             w_final;
    logic             w_s_hs;
    logic             w_start_hs;
    logic [15:0]      w_seq_inc;

    logic [2:0]       w_state_nxt;
    logic             w_load;
    logic [31:0]      w_load_data;
    logic [3:0]       w_load_keep;
    logic             w_load_last;
    logic             w_s_ready;
    logic             w_start_ready;
    logic             w_len_err;
    logic             w_seq_adv;

    // The output register may take a new word when it is empty or being drained.
    assign w_load_ok  = !r_tvalid || m_axis_tready;
    // Only meaningful in PAYLOAD, where r_len is known to be non-zero.
    assign w_final    = (r_word_cnt == (r_len - LEN_W'(1)));
    assign w_s_hs     = s_axis_tvalid && w_s_ready;
    assign w_start_hs = start_valid && w_start_ready;
    // Zero is reserved as "never sent", so the id wraps from FFFF to 0001.
    assign w_seq_inc  = (r_next_seq == 16'hFFFF) ? 16'h0001 : (r_next_seq + 16'd1);

    // Next-state, output-load and source-ready decisions for each packet phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_data   = '0;
        w_load_keep   = '0;
        w_load_last   = 1'b0;
        w_s_ready     = 1'b0;
        w_start_ready = 1'b0;
        w_len_err     = 1'b0;
        w_seq_adv     = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_start_ready = 1'b1;
                if (start_valid) begin
                    w_state_nxt = c_st_hdr_magic;
                end
            end
            c_st_hdr_magic: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_load_data = MAGIC;
                    w_load_keep = c_keep_all;
                    w_state_nxt = c_st_hdr_seq;
                end
            end
            c_st_hdr_seq: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_load_data = {16'h0000, r_next_seq};
                    w_load_keep = c_keep_all;
                    w_load_last = (r_len == '0);
                    w_seq_adv   = 1'b1;
                    w_state_nxt = (r_len == '0) ? c_st_idle : c_st_payload;
                end
            end
            c_st_payload: begin
                w_s_ready = w_load_ok;
                if (w_load_ok && s_axis_tvalid) begin
                    w_load      = 1'b1;
                    w_load_data = s_axis_tdata;
                    w_load_keep = s_axis_tkeep;
                    if (s_axis_tlast) begin
                        // Source ended; a short packet is sent truncated, not padded.
                        w_load_last = 1'b1;
                        w_len_err   = !w_final;
                        w_state_nxt = c_st_idle;
                    end else if (w_final) begin
                        // Declared length reached before the source ended: close
                        // the packet here and swallow the surplus words.
                        w_load_last = 1'b1;
                        w_len_err   = 1'b1;
                        w_state_nxt = c_st_drain;
                    end
                end
            end
            c_st_drain: begin
                w_s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Packet-phase state, latched length and payload word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_len      <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_hs) begin
                r_len      <= start_len;
                r_word_cnt <= '0;
            end else if (r_state == c_st_payload && w_s_hs) begin
                r_word_cnt <= r_word_cnt + LEN_W'(1);
            end
        end
    end

    // Single-stage output register; contents held stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_load) begin
            r_tdata  <= w_load_data;
            r_tkeep  <= w_load_keep;
            r_tlast  <= w_load_last;
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    // Sequence id carried by the next packet; advances as its header loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_seq <= SEQ_INIT;
        end else if (w_seq_adv) begin
            r_next_seq <= w_seq_inc;
        end
    end

    // Delivered-packet and length-mismatch statistics, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_tvalid && m_axis_tready && r_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_len_err) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign start_ready   = w_start_ready;
    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign pkt_sent_cnt  = r_pkt_cnt;
    assign len_err_cnt   = r_err_cnt;
    assign next_seq_id   = r_next_seq;
    assign busy          = (r_state != c_st_idle);

endmodule
`default_nettype wire
